// File: rtl/rotate_kick_ctrl_pkg.sv
// Shared playfield geometry, piece codes, sequencer states and the horizontal kick table
// for the rotation sequencer and its helpers.
package rotate_kick_ctrl_pkg;

  localparam int COLS      = 10;
  localparam int ROWS      = 20;
  localparam int CELLS     = COLS * ROWS;
  localparam int NUM_KICKS = 5;
  localparam int STD_KICKS = 3;

  localparam logic [3:0] I_BLOCK = 4'd1;
  localparam logic [3:0] O_BLOCK = 4'd2;
  localparam logic [3:0] T_BLOCK = 4'd3;
  localparam logic [3:0] S_BLOCK = 4'd4;
  localparam logic [3:0] Z_BLOCK = 4'd5;
  localparam logic [3:0] J_BLOCK = 4'd6;
  localparam logic [3:0] L_BLOCK = 4'd7;

  typedef logic [9:0]       coord_t;
  typedef logic [3:0][9:0]  cells_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROT   = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Kick order 0, +1, -1, +2, -2 as 10-bit two's complement column offsets.
  function automatic coord_t kick_dx(input logic [2:0] k);
    case (k)
      3'd1:    kick_dx = 10'd1;
      3'd2:    kick_dx = 10'h3FF;
      3'd3:    kick_dx = 10'd2;
      3'd4:    kick_dx = 10'h3FE;
      default: kick_dx = 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/rotate_kick_ctrl_cells_free_check.sv
// Combinational legality test for four cells against a board snapshot: every cell must be
// on the playfield and unoccupied. Negative coordinates wrap large and fail the range test.
module cells_free_check
  import rotate_kick_ctrl_pkg::*;
(
  input  cells_t             x,
  input  cells_t             y,
  input  logic [0:CELLS-1]   board,
  output logic               legal
);

  logic [3:0]      in_range;
  logic [3:0]      cell_ok;
  logic [3:0][7:0] idx;

  for (genvar i = 0; i < 4; i++) begin : g_cell
    assign in_range[i] = (x[i] < 10'(COLS)) && (y[i] < 10'(ROWS));
    // Only meaningful when in range; out-of-range cells are rejected before the lookup matters.
    assign idx[i]      = 8'((y[i] * COLS) + x[i]);
    assign cell_ok[i]  = in_range[i] && !board[idx[i]];
  end

  assign legal = &cell_ok;

endmodule

// File: rtl/rotate_kick_ctrl.sv
// Rotation sequencer: snapshots a rotate request, rotates the piece about cell 2, then tries
// horizontal wall kicks one per cycle and commits the first legal placement.
module rotate_kick_ctrl
  import rotate_kick_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rot_req,
  input  logic             rot_dir,
  input  logic [3:0]       current_block,
  input  logic [9:0]       ctrlX1,
  input  logic [9:0]       ctrlX2,
  input  logic [9:0]       ctrlX3,
  input  logic [9:0]       ctrlX4,
  input  logic [9:0]       ctrlY1,
  input  logic [9:0]       ctrlY2,
  input  logic [9:0]       ctrlY3,
  input  logic [9:0]       ctrlY4,
  input  logic [0:CELLS-1] boardMemory,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic [2:0]       kick_used,
  output logic [9:0]       newX1,
  output logic [9:0]       newX2,
  output logic [9:0]       newX3,
  output logic [9:0]       newX4,
  output logic [9:0]       newY1,
  output logic [9:0]       newY2,
  output logic [9:0]       newY3,
  output logic [9:0]       newY4
);

  state_t           state, state_next;
  logic [2:0]       k, k_last;
  logic             dir_q;
  logic [3:0]       block_q;
  cells_t           sx, sy, bx, by, rx, ry, cx, cy, nx, ny;
  logic [0:CELLS-1] board_q;
  logic             ok_q;
  logic [2:0]       kick_q;
  logic             legal;

  logic load_snap, load_base, k_inc, commit, fail, o_pass;

  // Only the I piece gets the wide +/-2 kicks; unknown codes fall back to the short list.
  assign k_last = (block_q == I_BLOCK) ? 3'(NUM_KICKS - 1) : 3'(STD_KICKS - 1);

  for (genvar i = 0; i < 4; i++) begin : g_rot
    coord_t dx, dy;
    assign dx    = sx[i] - sx[1];
    assign dy    = sy[i] - sy[1];
    assign rx[i] = dir_q ? (sx[1] + dy) : (sx[1] - dy);
    assign ry[i] = dir_q ? (sy[1] - dx) : (sy[1] + dx);
    assign cx[i] = bx[i] + kick_dx(k);
    assign cy[i] = by[i];
  end

  cells_free_check u_check (
    .x     (cx),
    .y     (cy),
    .board (board_q),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_snap  = 1'b0;
    load_base  = 1'b0;
    k_inc      = 1'b0;
    commit     = 1'b0;
    fail       = 1'b0;
    o_pass     = 1'b0;
    case (state)
      IDLE: begin
        if (rot_req) begin
          load_snap = 1'b1;
          if (current_block == O_BLOCK) begin
            o_pass     = 1'b1;
            state_next = FIN;
          end else begin
            state_next = ROT;
          end
        end
      end
      ROT: begin
        load_base  = 1'b1;
        state_next = CHECK;
      end
      CHECK: begin
        if (legal) begin
          commit     = 1'b1;
          state_next = FIN;
        end else if (k == k_last) begin
          fail       = 1'b1;
          state_next = FIN;
        end else begin
          k_inc = 1'b1;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= 1'b0;
      block_q <= '0;
      sx      <= '0;
      sy      <= '0;
      board_q <= '0;
      bx      <= '0;
      by      <= '0;
      k       <= '0;
      nx      <= '0;
      ny      <= '0;
      ok_q    <= 1'b0;
      kick_q  <= '0;
    end else begin
      if (load_snap) begin
        dir_q   <= rot_dir;
        block_q <= current_block;
        sx      <= {ctrlX4, ctrlX3, ctrlX2, ctrlX1};
        sy      <= {ctrlY4, ctrlY3, ctrlY2, ctrlY1};
        board_q <= boardMemory;
      end
      if (load_base) begin
        bx <= rx;
        by <= ry;
        k  <= '0;
      end
      if (k_inc) k <= k + 3'd1;
      if (o_pass) begin
        nx     <= {ctrlX4, ctrlX3, ctrlX2, ctrlX1};
        ny     <= {ctrlY4, ctrlY3, ctrlY2, ctrlY1};
        ok_q   <= 1'b1;
        kick_q <= '0;
      end
      if (commit) begin
        nx     <= cx;
        ny     <= cy;
        ok_q   <= 1'b1;
        kick_q <= k;
      end
      if (fail) ok_q <= 1'b0;
    end
  end

  assign busy      = (state == ROT) || (state == CHECK);
  assign done      = (state == FIN);
  assign ok        = ok_q;
  assign kick_used = kick_q;
  assign newX1 = nx[0];
  assign newX2 = nx[1];
  assign newX3 = nx[2];
  assign newX4 = nx[3];
  assign newY1 = ny[0];
  assign newY2 = ny[1];
  assign newY3 = ny[2];
  assign newY4 = ny[3];

endmodule

// File: tb/tb_rotate_kick_ctrl.sv
// Self-checking bench for rotate_kick_ctrl: table of rotate requests with a scoreboard
// queue, plus hand sequences for ignored requests and mid-operation reset.
module tb_rotate_kick_ctrl;
  import rotate_kick_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst, rot_req, rot_dir;
  logic [3:0] current_block;
  logic [9:0] ctrlX1, ctrlX2, ctrlX3, ctrlX4, ctrlY1, ctrlY2, ctrlY3, ctrlY4;
  logic [0:CELLS-1] boardMemory;
  logic busy, done, ok;
  logic [2:0] kick_used;
  logic [9:0] newX1, newX2, newX3, newX4, newY1, newY2, newY3, newY4;

  rotate_kick_ctrl dut (
    .clk(clk), .rst(rst), .rot_req(rot_req), .rot_dir(rot_dir), .current_block(current_block),
    .ctrlX1(ctrlX1), .ctrlX2(ctrlX2), .ctrlX3(ctrlX3), .ctrlX4(ctrlX4),
    .ctrlY1(ctrlY1), .ctrlY2(ctrlY2), .ctrlY3(ctrlY3), .ctrlY4(ctrlY4),
    .boardMemory(boardMemory), .busy(busy), .done(done), .ok(ok), .kick_used(kick_used),
    .newX1(newX1), .newX2(newX2), .newX3(newX3), .newX4(newX4),
    .newY1(newY1), .newY2(newY2), .newY3(newY3), .newY4(newY4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  blk;
    logic        dir;
    logic [39:0] x, y;
    int          brd;
    int          lat;
    logic        ok;
    logic [2:0]  kick;
    logic [39:0] ex, ey;
  } vec_t;

  typedef struct {
    int          req_cyc;
    int          lat;
    logic        ok;
    logic [2:0]  kick;
    logic [39:0] ex, ey;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[11];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   done_cnt = 0, exp_done = 0;
  logic [39:0] model_x = '0, model_y = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
    pk = {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  function automatic logic [0:CELLS-1] make_board(input int sel);
    logic [0:CELLS-1] b;
    b = '0;
    if (sel == 1) begin
      for (int yy = 3; yy <= 7; yy++)
        for (int xx = 0; xx < COLS; xx++) b[yy*COLS + xx] = 1'b1;
      for (int xx = 3; xx <= 6; xx++) b[5*COLS + xx] = 1'b0;
    end else if (sel == 2) begin
      b[6*COLS + 5] = 1'b1;
    end
    return b;
  endfunction

  task automatic drive(input vec_t v);
    rot_dir       = v.dir;
    current_block = v.blk;
    {ctrlX4, ctrlX3, ctrlX2, ctrlX1} = v.x;
    {ctrlY4, ctrlY3, ctrlY2, ctrlY1} = v.y;
    boardMemory   = make_board(v.brd);
  endtask

  task automatic scramble();
    current_block = 4'($urandom_range(0, 15));
    rot_dir       = 1'($urandom_range(0, 1));
    {ctrlX4, ctrlX3, ctrlX2, ctrlX1} = {$urandom, $urandom};
    {ctrlY4, ctrlY3, ctrlY2, ctrlY1} = {$urandom, $urandom};
    boardMemory   = '1;
  endtask

  task automatic push(input vec_t v);
    sb_t e;
    if (v.ok) begin
      model_x = v.ex;
      model_y = v.ey;
    end
    e.req_cyc = cyc;
    e.lat     = v.lat;
    e.ok      = v.ok;
    e.kick    = v.kick;
    e.ex      = model_x;
    e.ey      = model_y;
    sbq.push_back(e);
    exp_done++;
  endtask

  // Request is driven on a falling edge; the cycle it is sampled in counts as cycle 0.
  task automatic run(input vec_t v);
    bit seen;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    drive(v);
    rot_req = 1'b1;
    push(v);
    @(negedge clk);
    rot_req = 1'b0;
    scramble();
    seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      chk("busy", 64'(busy), 64'((v.blk != O_BLOCK) && !done));
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      sb_t e;
      done_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("latency", 64'(cyc - e.req_cyc), 64'(e.lat));
        chk("ok", 64'(ok), 64'(e.ok));
        if (e.ok) chk("kick_used", 64'(kick_used), 64'(e.kick));
        chk("newX", 64'({newX4, newX3, newX2, newX1}), 64'(e.ex));
        chk("newY", 64'({newY4, newY3, newY2, newY1}), 64'(e.ey));
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_ok"}, 64'(ok), 64'd0);
    chk({name, "_kick"}, 64'(kick_used), 64'd0);
    chk({name, "_newX"}, 64'({newX4, newX3, newX2, newX1}), 64'd0);
    chk({name, "_newY"}, 64'({newY4, newY3, newY2, newY1}), 64'd0);
  endtask

  initial begin
    //          blk      dir   x               y               brd lat ok kick ex              ey
    vecs[0]  = '{T_BLOCK, 1'b0, pk(4,5,6,5),   pk(5,5,5,4),    0,  3,  1, 0, pk(5,5,5,6), pk(4,5,6,5)};
    vecs[1]  = '{T_BLOCK, 1'b1, pk(0,0,0,1),   pk(4,5,6,5),    0,  4,  1, 1, pk(0,1,2,1), pk(5,5,5,4)};
    vecs[2]  = '{O_BLOCK, 1'b0, pk(2,3,2,3),   pk(0,0,1,1),    0,  1,  1, 0, pk(2,3,2,3), pk(0,0,1,1)};
    vecs[3]  = '{I_BLOCK, 1'b0, pk(3,4,5,6),   pk(5,5,5,5),    1,  7,  0, 0, '0, '0};
    vecs[4]  = '{I_BLOCK, 1'b0, pk(3,4,5,6),   pk(5,5,5,5),    0,  3,  1, 0, pk(4,4,4,4), pk(4,5,6,7)};
    vecs[5]  = '{I_BLOCK, 1'b0, pk(9,9,9,9),   pk(4,5,6,7),    0,  5,  1, 2, pk(9,8,7,6), pk(5,5,5,5)};
    vecs[6]  = '{4'hF,    1'b0, pk(0,0,0,0),   pk(4,5,6,7),    0,  5,  0, 0, '0, '0};
    vecs[7]  = '{I_BLOCK, 1'b0, pk(0,0,0,0),   pk(4,5,6,7),    0,  6,  1, 3, pk(3,2,1,0), pk(5,5,5,5)};
    vecs[8]  = '{T_BLOCK, 1'b0, pk(4,5,6,5),   pk(5,5,5,4),    2,  4,  1, 1, pk(6,6,6,7), pk(4,5,6,5)};
    vecs[9]  = '{L_BLOCK, 1'b1, pk(4,5,6,6),   pk(5,5,5,4),    0,  3,  1, 0, pk(5,5,5,4), pk(6,5,4,4)};
    vecs[10] = '{T_BLOCK, 1'b0, pk(4,5,6,5),   pk(0,0,0,1),    0,  5,  0, 0, '0, '0};

    rst = 1'b1;
    rot_req = 1'b0;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) run(vecs[i]);

    // Extra requests while busy and during the done cycle must be ignored.
    @(negedge clk);
    drive(vecs[0]);
    rot_req = 1'b1;
    push(vecs[0]);
    @(negedge clk);
    scramble();
    @(negedge clk);
    rot_req = 1'b0;
    @(negedge clk);
    chk("fin_done", 64'(done), 64'd1);
    drive(vecs[1]);
    rot_req = 1'b1;
    @(negedge clk);
    rot_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("ignored_busy", 64'(busy), 64'd0);

    // Reset in cycle 2 aborts the attempt with no done and clears everything.
    drive(vecs[0]);
    rot_req = 1'b1;
    @(negedge clk);
    rot_req = 1'b0;
    scramble();
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("abort");
    model_x = '0;
    model_y = '0;
    repeat (10) @(negedge clk);

    // Failure right after reset must leave the cleared coordinates in place.
    run(vecs[3]);
    repeat (3) @(negedge clk);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
